// File: rtl/lockstep_pkg.sv
// Shared types for the dual-core lockstep checker: FSM states, the per-core
// memory request bundle, error-vector bit positions and the field comparator.
package lockstep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_FAULT = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   typedef struct packed {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        we;
      logic [3:0]  be;
      logic [31:0] daddr;
      logic [31:0] wdata;
   } core_req_t;

   localparam int unsigned ERR_W     = 7;
   localparam int unsigned ERR_IREQ  = 0;
   localparam int unsigned ERR_IADDR = 1;
   localparam int unsigned ERR_DREQ  = 2;
   localparam int unsigned ERR_DADDR = 3;
   localparam int unsigned ERR_WE    = 4;
   localparam int unsigned ERR_BE    = 5;
   localparam int unsigned ERR_WDATA = 6;

   // Qualified compare: address/data fields only matter when either core
   // actually issues the request that gives them meaning.
   function automatic logic [ERR_W-1:0] compare_req(input core_req_t a, input core_req_t b);
      logic             any_ireq;
      logic             any_dreq;
      logic             any_we;
      logic [ERR_W-1:0] v;
      any_ireq = a.ireq | b.ireq;
      any_dreq = a.dreq | b.dreq;
      any_we   = a.we | b.we;
      v = '0;
      v[ERR_IREQ]  = (a.ireq != b.ireq);
      v[ERR_IADDR] = any_ireq && (a.iaddr != b.iaddr);
      v[ERR_DREQ]  = (a.dreq != b.dreq);
      v[ERR_DADDR] = any_dreq && (a.daddr != b.daddr);
      v[ERR_WE]    = any_dreq && (a.we != b.we);
      v[ERR_BE]    = any_dreq && any_we && (a.be != b.be);
      v[ERR_WDATA] = any_dreq && any_we && (a.wdata != b.wdata);
      return v;
   endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// DELAY-deep register pipeline for core 0 requests, so they line up with the
// lagging shadow core. DELAY=0 is a plain wire.
module lockstep_delay_line
   import lockstep_pkg::*;
#(
   parameter int unsigned DELAY = 0
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      flush_i,
   input  core_req_t req_i,
   output core_req_t req_o
);

   generate
      if (DELAY == 0) begin : g_bypass
         logic unused_ok;
         assign unused_ok = ^{clk_i, rst_ni, flush_i};
         assign req_o     = req_i;
      end else begin : g_pipe
         core_req_t stage_q [DELAY];

         // NOTE: the stages are reset and flushed, so a stale request from before
         // enable cannot reach the comparator once warm-up ends.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 0; i < int'(DELAY); i++) stage_q[i] <= '0;
            end else if (flush_i) begin
               for (int i = 0; i < int'(DELAY); i++) stage_q[i] <= '0;
            end else begin
               stage_q[0] <= req_i;
               for (int i = 1; i < int'(DELAY); i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign req_o = stage_q[DELAY-1];
      end
   endgenerate

endmodule

// File: rtl/lockstep_checker.sv
// Compares shadow core 1 memory requests against (optionally delayed) core 0,
// flags divergence, captures first-fault diagnostics and requests a halt.
module lockstep_checker
   import lockstep_pkg::*;
#(
   parameter int unsigned DELAY          = 0,
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned HALT_THRESHOLD = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              instr_req_0_i,
   input  logic              instr_req_1_i,
   input  logic [31:0]       instr_addr_0_i,
   input  logic [31:0]       instr_addr_1_i,
   input  logic              data_req_0_i,
   input  logic              data_req_1_i,
   input  logic              data_we_0_i,
   input  logic              data_we_1_i,
   input  logic [3:0]        data_be_0_i,
   input  logic [3:0]        data_be_1_i,
   input  logic [31:0]       data_addr_0_i,
   input  logic [31:0]       data_addr_1_i,
   input  logic [31:0]       data_wdata_0_i,
   input  logic [31:0]       data_wdata_1_i,
   output logic              mismatch_o,
   output logic              error_o,
   output logic [CNT_W-1:0]  err_count_o,
   output logic [ERR_W-1:0]  err_vec_o,
   output logic [31:0]       err_pc_o,
   output logic              halt_o,
   output logic [1:0]        state_o
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] HALT_CNT  = CNT_W'(HALT_THRESHOLD);
   localparam logic [1:0]       WARM_INIT = 2'(DELAY);

   core_req_t req0;
   core_req_t req1;
   core_req_t req0_dly;
   logic      flush;

   assign req0 = '{ireq: instr_req_0_i, iaddr: instr_addr_0_i, dreq: data_req_0_i,
                   we: data_we_0_i, be: data_be_0_i, daddr: data_addr_0_i,
                   wdata: data_wdata_0_i};
   assign req1 = '{ireq: instr_req_1_i, iaddr: instr_addr_1_i, dreq: data_req_1_i,
                   we: data_we_1_i, be: data_be_1_i, daddr: data_addr_1_i,
                   wdata: data_wdata_1_i};
   assign flush = ~enable_i;

   lockstep_delay_line #(
      .DELAY (DELAY)
   ) u_delay (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush),
      .req_i   (req0),
      .req_o   (req0_dly)
   );

   state_e             state_q;
   logic [1:0]         warm_q, warm_d;
   logic               mismatch_q;
   logic               error_q;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [ERR_W-1:0]   err_vec_q;
   logic [31:0]        err_pc_q;
   logic               halt_q, halt_d;

   logic [ERR_W-1:0]   diff_vec;
   logic               compare_en;
   logic               hit;

   assign diff_vec   = compare_req(req0_dly, req1);
   assign compare_en = enable_i && (state_q != ST_IDLE) && (warm_q == 2'd0);
   assign hit        = compare_en && (|diff_vec);

   // Warm-up reloads while waiting in IDLE, so it starts fresh on every entry to CHECK.
   always_comb begin
      warm_d = warm_q;
      if (!enable_i)                warm_d = 2'd0;
      else if (state_q == ST_IDLE)  warm_d = WARM_INIT;
      else if (warm_q != 2'd0)      warm_d = warm_q - 2'd1;

      err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_W'(1);
      halt_d    = (err_cnt_d >= HALT_CNT);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         warm_q     <= 2'd0;
         mismatch_q <= 1'b0;
         error_q    <= 1'b0;
         err_cnt_q  <= '0;
         err_vec_q  <= '0;
         err_pc_q   <= '0;
         halt_q     <= 1'b0;
      end else begin
         warm_q     <= warm_d;
         mismatch_q <= hit;
         if (clear_i) begin
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            err_vec_q <= '0;
            err_pc_q  <= '0;
            halt_q    <= 1'b0;
            state_q   <= enable_i ? ST_CHECK : ST_IDLE;
         end else if (!enable_i) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: state_q <= ST_CHECK;
               default: begin
                  if (hit) begin
                     error_q   <= 1'b1;
                     err_cnt_q <= err_cnt_d;
                     halt_q    <= halt_d;
                     if (!error_q) begin
                        err_vec_q <= diff_vec;
                        err_pc_q  <= req0_dly.iaddr;
                     end
                     state_q <= halt_d ? ST_HALT : ST_FAULT;
                  end
               end
            endcase
         end
      end
   end

   assign mismatch_o  = mismatch_q;
   assign error_o     = error_q;
   assign err_count_o = err_cnt_q;
   assign err_vec_o   = err_vec_q;
   assign err_pc_o    = err_pc_q;
   assign halt_o      = halt_q;
   assign state_o     = state_q;

endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
Dual-core output comparator placed downstream of the two zeroriscy cores in the dual-core SoC. Core 0 drives the memories; core 1 is the shadow core and receives identical responses. The block compares every memory-request output of core 1 against core 0, optionally with a fixed time offset. It flags divergence, captures first-fault diagnostics, counts faults and requests a halt once a threshold is reached.

Parameters:
DELAY, 0, cycles core 1 lags core 0 (legal 0..3); core 0 fields pass through a DELAY-deep register pipeline before comparison
CNT_W, 8, width of the saturating fault counter
HALT_THRESHOLD, 4, fault count at which halt_o asserts (1..2^CNT_W-1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  checking enabled (tie to fetch_enable_i)
clear_i  in  1  clears sticky error state, counter, captures and halt
instr_req_0_i / instr_req_1_i  in  1  instruction request, core 0 / core 1
instr_addr_0_i / instr_addr_1_i  in  32  instruction address
data_req_0_i / data_req_1_i  in  1  data request
data_we_0_i / data_we_1_i  in  1  data write enable
data_be_0_i / data_be_1_i  in  4  data byte enable
data_addr_0_i / data_addr_1_i  in  32  data address
data_wdata_0_i / data_wdata_1_i  in  32  data write data
mismatch_o  out  1  one-cycle pulse per mismatching compare cycle
error_o  out  1  sticky: at least one mismatch since last clear
err_count_o  out  CNT_W  saturating mismatch count
err_vec_o  out  7  fields that mismatched at first fault: {wdata,be,we,daddr,dreq,iaddr,ireq}, bit0 = ireq
err_pc_o  out  32  delayed core 0 instr_addr at first fault
halt_o  out  1  err_count_o >= HALT_THRESHOLD
state_o  out  2  current FSM state encoding

Behaviour:
- Reset: all outputs 0; state IDLE; delay pipeline and warm-up counter cleared.
- Field compare rules:
  - ireq and dreq are always compared.
  - iaddr is compared only when either ireq is 1.
  - we and daddr are compared only when either dreq is 1.
  - be and wdata are compared only when either dreq is 1 and either we is 1.
- Core 0 values pass through DELAY register stages (DELAY=0: no stages) before comparison. Core 1 values are never delayed.
- Warm-up: after entering CHECK from IDLE, comparison is suppressed for DELAY cycles while the pipeline fills.
- Latency: a combinational mismatch in cycle t produces mismatch_o=1 in cycle t+1. error_o, err_count_o and captures update at the same edge.
- FSM states:
  - IDLE=0: no compare. Goes to CHECK when enable_i=1.
  - CHECK=1: compare every cycle. Goes to FAULT on first mismatch, loading err_vec_o and err_pc_o.
  - FAULT=2: compare continues and captures are frozen. Goes to HALT when the count reaches HALT_THRESHOLD.
  - HALT=3: halt_o=1 and compare continues (counter keeps saturating).
- enable_i=0 in any state: go to IDLE next cycle. Sticky outputs and the counter are held. The pipeline is flushed to 0.
- clear_i=1 in any state:
  - Clears error_o, err_count_o, err_vec_o, err_pc_o and halt_o at the next edge.
  - Next state is CHECK if enable_i=1, else IDLE.
- clear_i wins over a simultaneous mismatch: that mismatch is not counted or captured, but mismatch_o still pulses.
- Counter: +1 per mismatching cycle; saturates at 2^CNT_W-1 and never wraps.
- halt_o is registered and asserts in the same cycle err_count_o first equals HALT_THRESHOLD.
- A mismatch during warm-up or in IDLE is ignored entirely (no pulse).

Decomposition:
- Package lockstep_pkg:
  - state enum (IDLE, CHECK, FAULT, HALT)
  - packed struct core_req_t {ireq, iaddr, dreq, we, be, daddr, wdata}
  - err-vector bit index constants
- One sub-module, lockstep_delay_line: a DELAY-deep register pipeline of core_req_t with async reset and synchronous flush.

Test Plan:
- DELAY=0, identical random traffic for 1000 cycles -> mismatch_o never 1, error_o=0, state_o=1.
- DELAY=0, cycle 50: instr_addr_1_i=0x104 vs 0x100, both ireq=1 -> cycle 51: mismatch_o=1, err_vec_o=7'h02, err_pc_o=0x100, err_count_o=1, state_o=2.
- Both dreq=1, we=0, wdata differs -> no mismatch. Then we=1 on both with wdata 0xDEADBEEF vs 0xDEADBEEE -> err_vec_o=7'h40.
- 4 consecutive mismatching cycles (threshold 4) -> err_count_o 1,2,3,4; halt_o=1 in the cycle count=4; state_o=3. Then clear_i with a simultaneous mismatch -> count=0, error_o=0, state_o=1, mismatch_o pulses once.
- DELAY=2, core 1 stimulus is core 0 shifted by 2 cycles -> no mismatch. Shift by 1 cycle instead -> mismatch within 4 cycles of first request.
- CNT_W=2, HALT_THRESHOLD=3, 10 mismatches -> err_count_o saturates at 3. enable_i=0 -> state_o=0 next cycle, with error_o and count held.
